// File: rtl/cond_eval_unit_pkg.sv
// Shared definitions for the condition evaluation unit: condition codes and FSM states.
package cond_eval_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/cond_eval_unit_if.sv
// Decode/flag-register side bundle for cond_eval_unit. master = requester, slave = unit.
interface cond_eval_unit_if;
  logic       N_in, Z_in, C_in, V_in;
  logic       Flag_Issue;
  logic       FR_Ld;
  logic       Req_Valid;
  logic [3:0] Cond;
  logic       Is_Branch;
  logic       Stall;
  logic       Cond_Valid;
  logic       Cond_True;
  logic       Take_Branch;
  logic       Err;

  modport master (
    output N_in, Z_in, C_in, V_in, Flag_Issue, FR_Ld, Req_Valid, Cond, Is_Branch,
    input  Stall, Cond_Valid, Cond_True, Take_Branch, Err
  );

  modport slave (
    input  N_in, Z_in, C_in, V_in, Flag_Issue, FR_Ld, Req_Valid, Cond, Is_Branch,
    output Stall, Cond_Valid, Cond_True, Take_Branch, Err
  );
endinterface

// File: rtl/cond_eval_unit_cond_check.sv
// Pure combinational condition test: 4-bit condition code against N/Z/C/V.
module cond_check
  import cond_eval_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic       n_i,
  input  logic       z_i,
  input  logic       c_i,
  input  logic       v_i,
  output logic       pass_o
);

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z_i;
      COND_NE: pass_o = !z_i;
      COND_CS: pass_o = c_i;
      COND_CC: pass_o = !c_i;
      COND_MI: pass_o = n_i;
      COND_PL: pass_o = !n_i;
      COND_VS: pass_o = v_i;
      COND_VC: pass_o = !v_i;
      COND_HI: pass_o = c_i && !z_i;
      COND_LS: pass_o = !c_i || z_i;
      COND_GE: pass_o = (n_i == v_i);
      COND_LT: pass_o = (n_i != v_i);
      COND_GT: pass_o = !z_i && (n_i == v_i);
      COND_LE: pass_o = z_i || (n_i != v_i);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_eval_unit.sv
// Conditional-execution resolver: holds decode until in-flight flag writers have
// landed, then evaluates the condition against the registered flags.
module cond_eval_unit
  import cond_eval_unit_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  cond_eval_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [3:0]       cond_q;
  logic             br_q;
  logic             valid_q, true_q, take_q;
  logic [3:0]       eval_cond;
  logic             pass;
  logic             inc, dec;

  assign inc = bus.Flag_Issue && !bus.FR_Ld;
  assign dec = bus.FR_Ld && !bus.Flag_Issue;

  // Overflow/underflow saturate the counter and latch the error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc) begin
      if (cnt_q == CNT_MAX) err_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // In WAIT the captured condition is tested; in IDLE the live request is.
  assign eval_cond = (state_q == ST_WAIT) ? cond_q : bus.Cond;

  cond_check u_cond_check (
    .cond_i (eval_cond),
    .n_i    (bus.N_in),
    .z_i    (bus.Z_in),
    .c_i    (bus.C_in),
    .v_i    (bus.V_in),
    .pass_o (pass)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      cond_q  <= 4'h0;
      br_q    <= 1'b0;
      valid_q <= 1'b0;
      true_q  <= 1'b0;
      take_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.Req_Valid) begin
            cond_q <= bus.Cond;
            br_q   <= bus.Is_Branch;
            // A writer issued alongside the request is younger; cnt_q ignores it.
            if (cnt_q == '0) begin
              valid_q <= 1'b1;
              true_q  <= pass;
              take_q  <= pass && bus.Is_Branch;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            valid_q <= 1'b1;
            true_q  <= pass;
            take_q  <= pass && br_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Stall       = ((state_q == ST_IDLE) && bus.Req_Valid && (cnt_q != '0)) ||
                           (state_q == ST_WAIT);
  assign bus.Cond_Valid  = valid_q;
  assign bus.Cond_True   = true_q;
  assign bus.Take_Branch = take_q;
  assign bus.Err         = err_q;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Directed bench for cond_eval_unit: vector table, full condition sweep, stall/counter sequences.
module tb_cond_eval_unit;

  logic Clk;
  logic Reset_n;
  int   total;
  int   bad;

  cond_eval_unit_if bus ();

  cond_eval_unit #(.CNT_W(2)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] cond;
    logic       br;
    logic [3:0] nzcv;
    logic       exp_t;
    logic       exp_tk;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Independent reference: base test per condition pair, low bit inverts.
  function automatic logic model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, b;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0:    b = z;
      3'd1:    b = cc;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = cc & ~z;
      3'd5:    b = (n == v);
      3'd6:    b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return c[0] ? ~b : b;
  endfunction

  // Request with cnt==0: no stall, result one cycle later.
  task automatic req_now(input logic [3:0] c, input logic br, input logic [3:0] f,
                         input logic et, input logic etk, input string name);
    {bus.N_in, bus.Z_in, bus.C_in, bus.V_in} = f;
    bus.Req_Valid = 1'b1;
    bus.Cond      = c;
    bus.Is_Branch = br;
    #1 chk({name, "_stall"}, bus.Stall, 1'b0);
    tick();
    bus.Req_Valid = 1'b0;
    chk({name, "_valid"}, bus.Cond_Valid, 1'b1);
    chk({name, "_true"},  bus.Cond_True,  et);
    chk({name, "_take"},  bus.Take_Branch, etk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{4'h1, 1'b1, 4'b0000, 1'b1, 1'b1};
    vecs[1]  = '{4'h8, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[2]  = '{4'h8, 1'b1, 4'b0110, 1'b0, 1'b0};
    vecs[3]  = '{4'h9, 1'b1, 4'b0110, 1'b1, 1'b1};
    vecs[4]  = '{4'hA, 1'b0, 4'b1001, 1'b1, 1'b0};
    vecs[5]  = '{4'hB, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[6]  = '{4'hC, 1'b1, 4'b0001, 1'b0, 1'b0};
    vecs[7]  = '{4'hD, 1'b1, 4'b0001, 1'b1, 1'b1};
    vecs[8]  = '{4'h2, 1'b1, 4'b1101, 1'b0, 1'b0};
    vecs[9]  = '{4'h5, 1'b0, 4'b0111, 1'b1, 1'b0};
    vecs[10] = '{4'h6, 1'b1, 4'b0001, 1'b1, 1'b1};
    vecs[11] = '{4'hF, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[12] = '{4'h4, 1'b1, 4'b1000, 1'b1, 1'b1};

    Reset_n = 1'b0;
    {bus.N_in, bus.Z_in, bus.C_in, bus.V_in} = 4'h0;
    bus.Flag_Issue = 1'b0;
    bus.FR_Ld      = 1'b0;
    bus.Req_Valid  = 1'b0;
    bus.Cond       = 4'h0;
    bus.Is_Branch  = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.Cond_Valid, 1'b0);
    chk("rst_true",  bus.Cond_True,  1'b0);
    chk("rst_take",  bus.Take_Branch, 1'b0);
    chk("rst_err",   bus.Err,        1'b0);
    chk("rst_stall", bus.Stall,      1'b0);
    Reset_n = 1'b1;
    tick();

    // EQ with Z=1 as a branch
    req_now(4'h0, 1'b1, 4'b0100, 1'b1, 1'b1, "eq_basic");
    chk("eq_basic_stall_after", bus.Stall, 1'b0);
    tick();
    chk("pulse_width", bus.Cond_Valid, 1'b0);
    chk("true_hold",   bus.Cond_True,  1'b1);

    for (int i = 0; i < 13; i++)
      req_now(vecs[i].cond, vecs[i].br, vecs[i].nzcv, vecs[i].exp_t, vecs[i].exp_tk,
              $sformatf("vec%0d", i));

    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++)
        req_now(4'(c), 1'b1, 4'(f), model(4'(c), 4'(f)), model(4'(c), 4'(f)),
                $sformatf("sweep_c%0h_f%0h", c, f));

    // back-to-back AL then NV
    bus.Req_Valid = 1'b1; bus.Cond = 4'hE; bus.Is_Branch = 1'b0;
    tick();
    chk("b2b_v1", bus.Cond_Valid, 1'b1);
    chk("b2b_t1", bus.Cond_True,  1'b1);
    bus.Cond = 4'hF;
    tick();
    bus.Req_Valid = 1'b0;
    chk("b2b_v2", bus.Cond_Valid, 1'b1);
    chk("b2b_t2", bus.Cond_True,  1'b0);
    tick();
    chk("b2b_v3", bus.Cond_Valid, 1'b0);

    // writer in flight: NE must see the post-load flags
    {bus.N_in, bus.Z_in, bus.C_in, bus.V_in} = 4'b0100;
    bus.Flag_Issue = 1'b1;
    tick();
    bus.Flag_Issue = 1'b0;
    bus.Req_Valid = 1'b1; bus.Cond = 4'h1; bus.Is_Branch = 1'b0;
    #1 chk("wait_stall_t1", bus.Stall, 1'b1);
    tick();
    bus.Cond = 4'hF;
    bus.FR_Ld = 1'b1;
    #1 chk("wait_stall_t2", bus.Stall, 1'b1);
    chk("wait_valid_t2", bus.Cond_Valid, 1'b0);
    tick();
    bus.FR_Ld = 1'b0;
    bus.Req_Valid = 1'b0;
    bus.Z_in = 1'b0;
    #1 chk("wait_stall_t3", bus.Stall, 1'b1);
    chk("wait_valid_t3", bus.Cond_Valid, 1'b0);
    tick();
    chk("wait_valid_t4", bus.Cond_Valid, 1'b1);
    chk("wait_true_t4",  bus.Cond_True,  1'b1);
    chk("wait_stall_t4", bus.Stall,      1'b0);

    // issue alongside a cnt==0 request: request is older, evaluates now
    {bus.N_in, bus.Z_in, bus.C_in, bus.V_in} = 4'b0100;
    bus.Flag_Issue = 1'b1;
    req_now(4'h0, 1'b0, 4'b0100, 1'b1, 1'b0, "issue_same");
    bus.Flag_Issue = 1'b0;
    // cnt=1; issue+load together keeps it at 1
    bus.Flag_Issue = 1'b1; bus.FR_Ld = 1'b1;
    tick();
    bus.Flag_Issue = 1'b0; bus.FR_Ld = 1'b0;
    chk("both_err", bus.Err, 1'b0);
    bus.Req_Valid = 1'b1; bus.Cond = 4'hE;
    #1 chk("both_stall_a", bus.Stall, 1'b1);
    tick();
    bus.Req_Valid = 1'b0; bus.FR_Ld = 1'b1;
    #1 chk("both_valid_a", bus.Cond_Valid, 1'b0);
    tick();
    bus.FR_Ld = 1'b0;
    chk("both_stall_b", bus.Stall, 1'b1);
    chk("both_valid_b", bus.Cond_Valid, 1'b0);
    tick();
    chk("both_valid_c", bus.Cond_Valid, 1'b1);
    chk("both_true_c",  bus.Cond_True,  1'b1);
    chk("both_stall_c", bus.Stall,      1'b0);

    // overflow: fourth issue saturates at 3 and raises Err
    bus.Flag_Issue = 1'b1;
    tick(); tick(); tick();
    chk("ovf_err_pre", bus.Err, 1'b0);
    tick();
    bus.Flag_Issue = 1'b0;
    chk("ovf_err", bus.Err, 1'b1);
    bus.FR_Ld = 1'b1;
    tick(); tick();
    bus.FR_Ld = 1'b0;
    bus.Req_Valid = 1'b1; bus.Cond = 4'hF; bus.Is_Branch = 1'b1;
    #1 chk("ovf_stall", bus.Stall, 1'b1);
    tick();
    bus.Req_Valid = 1'b0; bus.FR_Ld = 1'b1;
    tick();
    bus.FR_Ld = 1'b0;
    chk("ovf_valid_a", bus.Cond_Valid, 1'b0);
    tick();
    chk("ovf_valid_b", bus.Cond_Valid, 1'b1);
    chk("ovf_true_b",  bus.Cond_True,  1'b0);
    chk("ovf_take_b",  bus.Take_Branch, 1'b0);
    chk("ovf_err_hold", bus.Err, 1'b1);

    // reset clears Err; underflow sets it, cnt stays 0
    #2 Reset_n = 1'b0;
    #1 chk("rst2_err", bus.Err, 1'b0);
    Reset_n = 1'b1;
    tick();
    bus.FR_Ld = 1'b1;
    tick();
    bus.FR_Ld = 1'b0;
    chk("udf_err", bus.Err, 1'b1);
    req_now(4'hE, 1'b1, 4'b0000, 1'b1, 1'b1, "udf_cnt0");

    // reset mid-WAIT drops the request
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    bus.Flag_Issue = 1'b1;
    tick();
    bus.Flag_Issue = 1'b0;
    bus.Req_Valid = 1'b1; bus.Cond = 4'hE; bus.Is_Branch = 1'b1;
    tick();
    bus.Req_Valid = 1'b0;
    #1 chk("mid_stall", bus.Stall, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_stall", bus.Stall,       1'b0);
    chk("mid_rst_valid", bus.Cond_Valid,  1'b0);
    chk("mid_rst_err",   bus.Err,         1'b0);
    #2 Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_novalid%0d", k), bus.Cond_Valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
